counter_seq_ctrl: RTL and testbench
===================================

// Module: counter_seq_ctrl
// PURPOSE
//  Sequencer for the 8-bit programmable up/down counter. Accepts a count command over a
//  valid/ready handshake, then drives the counter's load/enable/direction/output-enable controls.
//  Loads the start value, steps the counter at a programmable rate until it equals the target,
//  and signals completion. Sits between the host/register interface and the counter datapath.
// PARAMETERS
//  WIDTH   8  counter, start and target width
//  PRE_W   8  prescaler field width; the counter steps once every (prescale+1) clocks
//  RLD_W   8  width of the reload (wrap) event counter
// PORTS
//  clk            in   1      clock; every flop updates on its rising edge
//  rst            in   1      synchronous reset, active-high
//  cmd_valid      in   1      command present
//  cmd_ready      out  1      controller accepts a command; high only in IDLE
//  cmd_start      in   WIDTH  value loaded into the counter
//  cmd_target     in   WIDTH  terminal value
//  cmd_dir        in   1      0 = up, 1 = down
//  cmd_reload     in   1      1 = on terminal, reload start and repeat until abort
//  cmd_prescale   in   PRE_W  step interval minus 1
//  pause          in   1      freezes stepping and the prescaler; state is held
//  abort          in   1      ends the current command
//  cnt_q          in   WIDTH  current counter value (feedback)
//  cnt_load       out  1      counter load strobe
//  cnt_load_val   out  WIDTH  value presented with cnt_load
//  cnt_en         out  1      counter step enable
//  cnt_dir        out  1      counter direction
//  cnt_oe         out  1      counter output-enable (tri-state control)
//  busy           out  1      high in LOAD/RUN
//  done           out  1      one-cycle pulse when a non-reload command completes
//  aborted        out  1      one-cycle pulse when a command is aborted
//  reload_cnt     out  RLD_W  number of terminal reloads in the current command; saturates
// BEHAVIOUR
//  Reset: state=IDLE; every output is 0 except cmd_ready=1. Latched command fields clear to 0.
//  States: IDLE -> LOAD -> RUN -> (DONE | LOAD) -> IDLE.
//  IDLE:
//   - cmd_valid&cmd_ready latches all cmd_* fields.
//   - Next state is LOAD. reload_cnt clears to 0.
//  LOAD (1 cycle):
//   - cnt_load=1, cnt_load_val=latched start.
//   - Prescaler clears to 0. Next state is RUN.
//  RUN, evaluated each cycle in this priority:
//   - abort: go to IDLE, aborted=1 next cycle.
//   - cnt_q==target with cmd_reload=0: go to DONE.
//   - cnt_q==target with cmd_reload=1: go to LOAD, reload_cnt+1 (saturating).
//   - pause: hold state.
//   - Otherwise, when the prescaler reaches prescale: cnt_en=1 for one cycle and the prescaler
//     clears; else the prescaler increments.
//  cnt_en is combinational from the registered state, the prescaler and cnt_q, so no step is
//  issued in the cycle where cnt_q==target (no overshoot). The counter updates one cycle after cnt_en.
//  Zero-step case: start==target gives LOAD, then RUN (1 cycle, no cnt_en), then DONE.
//  Wrap-around is legal; up/down arithmetic is modulo 2^WIDTH.
//  Example: start 0xFE, target 0x01, up = 3 steps.
//  DONE (1 cycle): done=1, then IDLE.
//  abort in LOAD or DONE: abort has priority, go to IDLE with aborted=1. done never asserts
//  in the same cycle as aborted.
//  cnt_dir = latched dir in all states.
//  cnt_oe = 1 in LOAD, RUN and DONE; 0 in IDLE.
//  rst asserted mid-command: next cycle is IDLE with reset outputs; no done or aborted pulse.
// STRUCTURE
//  Package counter_seq_pkg: state encoding constants (IDLE, LOAD, RUN, DONE) and command
//  field widths.
//  Sub-module ctrl_tick_gen: PRE_W prescaler with clear, freeze (pause) and interval inputs;
//  outputs the tick.
//  Top: FSM, command latch, reload counter, output decode.
// TESTING
//  1. start 0x10, target 0x14, up, prescale 0 -> one LOAD cycle, 4 consecutive cnt_en cycles, then
//     done pulse 1 cycle after cnt_q==0x14. No 5th step.
//  2. start 0x02, target 0xFE, down, prescale 2 -> 4 steps, each 3 clocks apart; wraps 0x00->0xFF;
//     then done.
//  3. start==target==0x55 -> LOAD, then RUN with cnt_en never high, then done; cnt_oe low after IDLE.
//  4. reload=1, start 0, target 3, up -> reload_cnt reaches 3 after three terminals.
//     abort during the 4th pass -> aborted=1, no done, cmd_ready back high.
//  5. pause held 5 cycles mid-RUN at prescaler=1 -> no cnt_en and prescaler frozen; stepping
//     resumes at the same phase.
//  6. rst during RUN, and cmd_valid while busy -> IDLE with all outputs 0 except cmd_ready;
//     the command is not accepted until IDLE.

Source files
------------

// File: rtl/counter_seq_pkg.sv
// rtl/counter_seq_pkg.sv - shared state encoding and default field widths for the counter sequencer
package counter_seq_pkg;

    localparam int CNT_W_DEF = 8;
    localparam int PRE_W_DEF = 8;
    localparam int RLD_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } seq_state_e;

endpackage

// File: rtl/counter_seq_ctrl_if.sv
// rtl/counter_seq_ctrl_if.sv - command handshake and counter control bundle
// master: host/datapath side (drives cmd_*, pause, abort, cnt_q)
// slave : sequencer side (drives cmd_ready, cnt_* controls, status)
interface counter_seq_ctrl_if import counter_seq_pkg::*; #(
    parameter int WIDTH = CNT_W_DEF,
    parameter int PRE_W = PRE_W_DEF,
    parameter int RLD_W = RLD_W_DEF
) ();

    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_start;
    logic [WIDTH-1:0] cmd_target;
    logic             cmd_dir;
    logic             cmd_reload;
    logic [PRE_W-1:0] cmd_prescale;
    logic             pause;
    logic             abort;
    logic [WIDTH-1:0] cnt_q;
    logic             cnt_load;
    logic [WIDTH-1:0] cnt_load_val;
    logic             cnt_en;
    logic             cnt_dir;
    logic             cnt_oe;
    logic             busy;
    logic             done;
    logic             aborted;
    logic [RLD_W-1:0] reload_cnt;

    modport master (
        output cmd_valid, cmd_start, cmd_target, cmd_dir, cmd_reload, cmd_prescale,
        output pause, abort, cnt_q,
        input  cmd_ready, cnt_load, cnt_load_val, cnt_en, cnt_dir, cnt_oe,
        input  busy, done, aborted, reload_cnt
    );

    modport slave (
        input  cmd_valid, cmd_start, cmd_target, cmd_dir, cmd_reload, cmd_prescale,
        input  pause, abort, cnt_q,
        output cmd_ready, cnt_load, cnt_load_val, cnt_en, cnt_dir, cnt_oe,
        output busy, done, aborted, reload_cnt
    );

endinterface

// File: rtl/ctrl_tick_gen.sv
// rtl/ctrl_tick_gen.sv - step prescaler: one tick every (interval_i+1) enabled, unfrozen clocks
// clk, rst     : clock, synchronous active-high reset
// clr_i        : force the prescaler back to 0
// en_i         : stepping allowed this cycle
// frz_i        : hold the prescaler (pause)
// interval_i   : step interval minus 1
// tick_o       : step request, combinational
module ctrl_tick_gen import counter_seq_pkg::*; #(
    parameter int PRE_W = PRE_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             frz_i,
    input  logic [PRE_W-1:0] interval_i,
    output logic             tick_o
);

    logic [PRE_W-1:0] pre_q;
    logic [PRE_W-1:0] pre_d;
    logic             adv;

    assign adv    = en_i & ~frz_i;
    assign tick_o = adv & (pre_q == interval_i);

    always_comb begin
        pre_d = pre_q;
        if (clr_i || tick_o) begin
            pre_d = '0;
        end else if (adv) begin
            pre_d = pre_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

endmodule

// File: rtl/counter_seq_ctrl.sv
// rtl/counter_seq_ctrl.sv - command sequencer driving load/step/direction/oe of the up/down counter
// clk, rst : clock, synchronous active-high reset
// bus      : slave side of counter_seq_ctrl_if (command handshake, counter controls, status)
module counter_seq_ctrl import counter_seq_pkg::*; #(
    parameter int WIDTH = CNT_W_DEF,
    parameter int PRE_W = PRE_W_DEF,
    parameter int RLD_W = RLD_W_DEF
) (
    input logic               clk,
    input logic               rst,
    counter_seq_ctrl_if.slave bus
);

    seq_state_e       state_q, state_d;
    logic [WIDTH-1:0] start_q, target_q;
    logic             dir_q, reload_q;
    logic [PRE_W-1:0] prescale_q;
    logic [RLD_W-1:0] rld_q, rld_d;
    logic             aborted_q, aborted_d;

    logic accept;
    logic at_target;
    logic step_ok;
    logic tick;

    assign accept    = (state_q == ST_IDLE) && bus.cmd_valid;
    assign at_target = (bus.cnt_q == target_q);
    // Stepping is only legal while RUN is not leaving this cycle; this keeps
    // cnt_en low in the cycle that sees the target, so the counter never overshoots.
    assign step_ok   = (state_q == ST_RUN) && !bus.abort && !at_target;

    ctrl_tick_gen #(.PRE_W(PRE_W)) u_tick (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (state_q == ST_LOAD),
        .en_i       (step_ok),
        .frz_i      (bus.pause),
        .interval_i (prescale_q),
        .tick_o     (tick)
    );

    always_comb begin
        state_d   = state_q;
        rld_d     = rld_q;
        aborted_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_LOAD;
                    rld_d   = '0;
                end
            end
            ST_LOAD: begin
                if (bus.abort) begin
                    state_d   = ST_IDLE;
                    aborted_d = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.abort) begin
                    state_d   = ST_IDLE;
                    aborted_d = 1'b1;
                end else if (at_target && !reload_q) begin
                    state_d = ST_DONE;
                end else if (at_target) begin
                    state_d = ST_LOAD;
                    rld_d   = (&rld_q) ? rld_q : rld_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d   = ST_IDLE;
                aborted_d = bus.abort;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            start_q    <= '0;
            target_q   <= '0;
            dir_q      <= 1'b0;
            reload_q   <= 1'b0;
            prescale_q <= '0;
            rld_q      <= '0;
            aborted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            rld_q     <= rld_d;
            aborted_q <= aborted_d;
            if (accept) begin
                start_q    <= bus.cmd_start;
                target_q   <= bus.cmd_target;
                dir_q      <= bus.cmd_dir;
                reload_q   <= bus.cmd_reload;
                prescale_q <= bus.cmd_prescale;
            end
        end
    end

    assign bus.cmd_ready    = (state_q == ST_IDLE);
    assign bus.cnt_load     = (state_q == ST_LOAD);
    assign bus.cnt_load_val = (state_q == ST_LOAD) ? start_q : '0;
    assign bus.cnt_en       = tick;
    assign bus.cnt_dir      = dir_q;
    assign bus.cnt_oe       = (state_q != ST_IDLE);
    assign bus.busy         = (state_q == ST_LOAD) || (state_q == ST_RUN);
    // An abort arriving in DONE wins, so done and aborted never pair up.
    assign bus.done         = (state_q == ST_DONE) && !bus.abort;
    assign bus.aborted      = aborted_q;
    assign bus.reload_cnt   = rld_q;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// tb/tb_counter_seq_ctrl.sv - self-checking bench for counter_seq_ctrl
module tb_counter_seq_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    counter_seq_ctrl_if #(.WIDTH(8), .PRE_W(8), .RLD_W(8)) bus ();

    counter_seq_ctrl #(.WIDTH(8), .PRE_W(8), .RLD_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Counter datapath stand-in: load wins over step, wraps modulo 256.
    always @(posedge clk) begin
        if (rst)               bus.cnt_q <= 8'h00;
        else if (bus.cnt_load) bus.cnt_q <= bus.cnt_load_val;
        else if (bus.cnt_en)   bus.cnt_q <= bus.cnt_dir ? bus.cnt_q - 8'h01 : bus.cnt_q + 8'h01;
    end

    // Per-cycle trace, offset 0 = cycle in which the command is offered.
    bit         tr_en[$], tr_load[$], tr_done[$], tr_abt[$], tr_ready[$], tr_oe[$], tr_busy[$], tr_dir[$];
    logic [7:0] tr_cnt[$], tr_rc[$], tr_lval[$];

    // Reference: steps to go, step k issued at offset 1+k*(p+1), later by the pause length
    // if the step falls at/after the pause start.
    function automatic int n_steps(input logic [7:0] s, input logic [7:0] t, input bit d);
        logic [7:0] diff;
        diff = d ? s - t : t - s;
        return int'(diff);
    endfunction

    function automatic bit exp_en(input int o, input int n, input int p, input int pa, input int pl);
        for (int k = 1; k <= n; k++) begin
            int e;
            e = 1 + k * (p + 1);
            if (pl > 0 && e >= pa) e += pl;
            if (e == o) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [7:0] exp_cnt(input logic [7:0] s, input bit d, input int o,
                                           input int n, input int p, input int pa, input int pl);
        logic [7:0] c;
        c = 8'h00;
        for (int k = 1; k <= n; k++) begin
            int e;
            e = 1 + k * (p + 1);
            if (pl > 0 && e >= pa) e += pl;
            if (e < o) c = c + 8'h01;
        end
        return d ? s - c : s + c;
    endfunction

    task automatic run_cmd(input logic [7:0] s, input logic [7:0] t, input bit d, input bit rl,
                           input logic [7:0] pv, input int pause_at, input int pause_len,
                           input int abort_at, input int rst_at, input int junk_from,
                           input int junk_len, input int max_cyc);
        tr_en.delete(); tr_load.delete(); tr_done.delete(); tr_abt.delete(); tr_ready.delete();
        tr_oe.delete(); tr_busy.delete(); tr_dir.delete(); tr_cnt.delete(); tr_rc.delete(); tr_lval.delete();
        @(negedge clk);
        bus.cmd_start = s; bus.cmd_target = t; bus.cmd_dir = d; bus.cmd_reload = rl;
        bus.cmd_prescale = pv; bus.cmd_valid = 1'b1;
        for (int o = 0; o <= max_cyc; o++) begin
            if (o > 0) begin
                @(negedge clk);
                bus.cmd_valid = (o >= junk_from) && (o < junk_from + junk_len);
                if (bus.cmd_valid) begin
                    bus.cmd_start = ~s; bus.cmd_target = ~t; bus.cmd_dir = ~d; bus.cmd_prescale = 8'h07;
                end
                bus.pause = (o >= pause_at) && (o < pause_at + pause_len);
                bus.abort = (o == abort_at);
                rst       = (o == rst_at);
            end
            #1;
            tr_en.push_back(bus.cnt_en);     tr_load.push_back(bus.cnt_load); tr_done.push_back(bus.done);
            tr_abt.push_back(bus.aborted);   tr_ready.push_back(bus.cmd_ready); tr_oe.push_back(bus.cnt_oe);
            tr_busy.push_back(bus.busy);     tr_dir.push_back(bus.cnt_dir);   tr_cnt.push_back(bus.cnt_q);
            tr_rc.push_back(bus.reload_cnt); tr_lval.push_back(bus.cnt_load_val);
            if (o > 0 && (bus.done || bus.aborted)) break;
            if (rst_at >= 0 && o == rst_at + 4) break;
        end
        bus.cmd_valid = 1'b0; bus.pause = 1'b0; bus.abort = 1'b0; rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b want 1", bus.cmd_ready);
        end
        checks++;
        if ({bus.cnt_load, bus.cnt_load_val, bus.cnt_en, bus.cnt_dir, bus.cnt_oe, bus.busy,
             bus.done, bus.aborted, bus.reload_cnt} !== 23'h0) begin
            errors++; $display("FAIL reset_outputs: got load=%b lval=%h en=%b dir=%b oe=%b busy=%b done=%b abt=%b rc=%h want all 0",
                bus.cnt_load, bus.cnt_load_val, bus.cnt_en, bus.cnt_dir, bus.cnt_oe, bus.busy,
                bus.done, bus.aborted, bus.reload_cnt);
        end
        rst = 1'b0;
    endtask

    task automatic test_stepping();
        int ts[4] = '{'h10, 'h02, 'h55, 'hFE};
        int tt[4] = '{'h14, 'hFE, 'h55, 'h01};
        int td[4] = '{0, 1, 0, 0};
        int tp[4] = '{0, 2, 0, 1};
        for (int i = 0; i < 10; i++) begin
            logic [7:0] s, t;
            bit d;
            int p, n, dn, last, bad;
            if (i < 4) begin
                s = 8'(ts[i]); t = 8'(tt[i]); d = td[i][0]; p = tp[i];
            end else begin
                s = 8'($urandom); d = 1'($urandom);
                n = int'($urandom_range(0, 12));
                t = d ? s - 8'(n) : s + 8'(n);
                p = int'($urandom_range(0, 4));
            end
            n  = n_steps(s, t, d);
            dn = n * (p + 1) + 3;
            run_cmd(s, t, d, 1'b0, 8'(p), -1, 0, -1, -1, -1, 0, dn + 20);
            last = tr_done.size() - 1;
            checks++;
            if (tr_ready[0] !== 1'b1) begin
                errors++; $display("FAIL step%0d_accept_ready: got %b want 1", i, tr_ready[0]);
            end
            checks++;
            if (last != dn || tr_done[last] !== 1'b1) begin
                errors++; $display("FAIL step%0d_done_offset: got %0d (done=%b) want %0d", i, last, tr_done[last], dn);
            end
            bad = 0;
            for (int o = 0; o <= last; o++) if (tr_en[o] !== exp_en(o, n, p, -1, 0)) bad++;
            checks++;
            if (bad != 0) begin
                errors++; $display("FAIL step%0d_en_timing: got %0d bad cycles want 0 (steps %0d prescale %0d)", i, bad, n, p);
            end
            bad = 0;
            for (int o = 0; o <= last; o++)
                if (tr_load[o] !== (o == 1) || (o == 1 && tr_lval[o] !== s)) bad++;
            checks++;
            if (bad != 0) begin
                errors++; $display("FAIL step%0d_load: got %0d bad cycles want 0", i, bad);
            end
            bad = 0;
            for (int o = 1; o <= last; o++)
                if (tr_oe[o] !== 1'b1 || tr_dir[o] !== d || tr_ready[o] !== 1'b0 ||
                    tr_busy[o] !== (o < dn) || tr_abt[o] !== 1'b0 || tr_done[o] !== (o == dn)) bad++;
            checks++;
            if (bad != 0) begin
                errors++; $display("FAIL step%0d_controls: got %0d bad cycles want 0", i, bad);
            end
            bad = 0;
            for (int o = 2; o <= last; o++) if (tr_cnt[o] !== exp_cnt(s, d, o, n, p, -1, 0)) bad++;
            checks++;
            if (bad != 0 || tr_cnt[last] !== t) begin
                errors++; $display("FAIL step%0d_count: got final %h (%0d bad cycles) want %h", i, tr_cnt[last], bad, t);
            end
            @(negedge clk); #1;
            checks++;
            if (bus.cnt_oe !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
                errors++; $display("FAIL step%0d_idle_after: got oe=%b ready=%b busy=%b want 0 1 0", i, bus.cnt_oe, bus.cmd_ready, bus.busy);
            end
        end
    endtask

    task automatic test_pause();
        int n, dn, last, bad;
        n  = 16;
        dn = n * 4 + 3 + 5;
        run_cmd(8'h20, 8'h30, 1'b0, 1'b0, 8'd3, 7, 5, -1, -1, -1, 0, dn + 20);
        last = tr_done.size() - 1;
        checks++;
        if (last != dn || tr_done[last] !== 1'b1) begin
            errors++; $display("FAIL pause_done_offset: got %0d want %0d", last, dn);
        end
        bad = 0;
        for (int o = 7; o < 12 && o <= last; o++) if (tr_en[o] !== 1'b0) bad++;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL pause_no_step: got %0d steps during pause want 0", bad);
        end
        bad = 0;
        for (int o = 0; o <= last; o++) if (tr_en[o] !== exp_en(o, n, 3, 7, 5)) bad++;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL pause_phase: got %0d bad cycles want 0", bad);
        end
        checks++;
        if (tr_cnt[last] !== 8'h30) begin
            errors++; $display("FAIL pause_final: got %h want 30", tr_cnt[last]);
        end
    endtask

    task automatic test_saturate();
        int last, bad;
        run_cmd(8'h77, 8'h77, 1'b0, 1'b1, 8'd0, -1, 0, 601, -1, -1, 0, 610);
        last = tr_abt.size() - 1;
        checks++;
        if (last != 602 || tr_rc[509] !== 8'd254 || tr_rc[511] !== 8'd255 || tr_rc[600] !== 8'd255) begin
            errors++; $display("FAIL sat_reload_cnt: got end %0d rc509=%0d rc511=%0d rc600=%0d want 602 254 255 255",
                last, tr_rc[509], tr_rc[511], tr_rc[600]);
        end
        bad = 0;
        for (int o = 0; o <= last; o++) if (tr_en[o] !== 1'b0 || tr_done[o] !== 1'b0) bad++;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL sat_no_step_no_done: got %0d bad cycles want 0", bad);
        end
        checks++;
        if (tr_abt[last] !== 1'b1 || tr_ready[last] !== 1'b1 || tr_oe[last] !== 1'b0) begin
            errors++; $display("FAIL abort_in_load: got abt=%b ready=%b oe=%b want 1 1 0", tr_abt[last], tr_ready[last], tr_oe[last]);
        end
    endtask

    task automatic test_reload();
        int p, len, last, bad;
        p   = int'($urandom_range(0, 2));
        len = 3 * (p + 1) + 2;
        run_cmd(8'h00, 8'h03, 1'b0, 1'b1, 8'(p), -1, 0, 3 * len + 3, -1, -1, 0, 3 * len + 10);
        last = tr_abt.size() - 1;
        checks++;
        if (tr_rc[1] !== 8'd0) begin
            errors++; $display("FAIL reload_clear: got %0d want 0", tr_rc[1]);
        end
        checks++;
        if (last < 3 * len + 1 || tr_rc[3 * len] !== 8'd2 || tr_rc[3 * len + 1] !== 8'd3) begin
            errors++; $display("FAIL reload_count: got rc=%0d then %0d want 2 then 3", tr_rc[3 * len], tr_rc[3 * len + 1]);
        end
        bad = 0;
        for (int o = 0; o <= last; o++)
            if (tr_load[o] !== (o == 1 || o == 1 + len || o == 1 + 2 * len || o == 1 + 3 * len)) bad++;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL reload_loads: got %0d bad cycles want 0", bad);
        end
        bad = 0;
        for (int o = 0; o <= last; o++) if (tr_done[o] !== 1'b0) bad++;
        checks++;
        if (last != 3 * len + 4 || tr_abt[last] !== 1'b1 || tr_ready[last] !== 1'b1 || bad != 0) begin
            errors++; $display("FAIL reload_abort: got end %0d abt=%b ready=%b dones=%0d want %0d 1 1 0",
                last, tr_abt[last], tr_ready[last], bad, 3 * len + 4);
        end
        @(negedge clk); #1;
        checks++;
        if (bus.aborted !== 1'b0) begin
            errors++; $display("FAIL abort_one_cycle: got %b want 0", bus.aborted);
        end
    endtask

    task automatic test_abort_done();
        int last, bad;
        run_cmd(8'h40, 8'h41, 1'b0, 1'b0, 8'd0, -1, 0, 4, -1, -1, 0, 12);
        last = tr_abt.size() - 1;
        bad = 0;
        for (int o = 0; o <= last; o++) if (tr_done[o] !== 1'b0) bad++;
        checks++;
        if (last != 5 || tr_abt[last] !== 1'b1 || bad != 0) begin
            errors++; $display("FAIL abort_in_done: got end %0d abt=%b dones=%0d want 5 1 0", last, tr_abt[last], bad);
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        run_cmd(8'h00, 8'h80, 1'b0, 1'b0, 8'd1, -1, 0, -1, 10, 8, 3, 14);
        bad = 0;
        for (int o = 11; o <= 14; o++)
            if (tr_ready[o] !== 1'b1 || tr_load[o] !== 1'b0 || tr_lval[o] !== 8'h00 || tr_en[o] !== 1'b0 ||
                tr_oe[o] !== 1'b0 || tr_busy[o] !== 1'b0 || tr_dir[o] !== 1'b0 || tr_rc[o] !== 8'h00) bad++;
        checks++;
        if (tr_cnt.size() != 15 || bad != 0) begin
            errors++; $display("FAIL rst_mid_idle: got %0d bad idle cycles (trace %0d) want 0 (15)", bad, tr_cnt.size());
        end
        bad = 0;
        for (int o = 0; o < tr_cnt.size(); o++)
            if (tr_done[o] !== 1'b0 || tr_abt[o] !== 1'b0 || tr_load[o] !== (o == 1)) bad++;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL rst_mid_no_pulse: got %0d bad cycles want 0", bad);
        end
    endtask

    task automatic test_back_to_back();
        int last, bad;
        run_cmd(8'h30, 8'h33, 1'b0, 1'b0, 8'd1, -1, 0, -1, -1, 2, 4, 40);
        last = tr_done.size() - 1;
        bad = 0;
        for (int o = 0; o <= last; o++) if (tr_load[o] !== (o == 1) || tr_en[o] !== exp_en(o, 3, 1, -1, 0)) bad++;
        checks++;
        if (last != 9 || tr_cnt[last] !== 8'h33 || bad != 0) begin
            errors++; $display("FAIL busy_cmd_ignored: got end %0d cnt %h bad %0d want 9 33 0", last, tr_cnt[last], bad);
        end
        run_cmd(8'hC8, 8'hC6, 1'b1, 1'b0, 8'd0, -1, 0, -1, -1, -1, 0, 40);
        last = tr_done.size() - 1;
        checks++;
        if (tr_ready[0] !== 1'b1 || tr_load[1] !== 1'b1 || last != 5 || tr_cnt[last] !== 8'hC6) begin
            errors++; $display("FAIL back_to_back: got ready=%b load=%b end %0d cnt %h want 1 1 5 c6",
                tr_ready[0], tr_load[1], last, tr_cnt[last]);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_start = 8'h00; bus.cmd_target = 8'h00; bus.cmd_dir = 1'b0;
        bus.cmd_reload = 1'b0; bus.cmd_prescale = 8'h00; bus.pause = 1'b0; bus.abort = 1'b0;
        test_reset();
        test_stepping();
        test_pause();
        test_saturate();
        test_reload();
        test_abort_done();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
